rr_decoder_arbiter: RTL and testbench
=====================================

# rr_decoder_arbiter

Round-robin arbiter that shares one N-output decoder between N requesters. Each cycle it owns the decoder's enable and select inputs, and it also produces the decoded one-hot grant vector. It sits between the request sources (switch/button logic, display users) and the decoder datapath. It guarantees that at most one requester is granted at a time, with a dead cycle between owners.

## Interface
- SEL_W, default 2: select width; number of requesters N = 2**SEL_W (2 → 2-to-4, 3 → 3-to-8).
- MAX_HOLD, default 16: maximum grant length in cycles when the timeout feature is compiled in; legal range 2..255.

- clk  input  1  rising-edge clock, the only clock.
- reset_n  input  1  reset; asynchronous and active-low.
- req  input  N  request per requester, level-sensitive, held until serviced.
- done  input  1  current owner releases the grant (one-cycle pulse).
- grant_en  output  1  decoder enable; high only while a grant is active.
- grant_sel  output  SEL_W  decoder select, the index of the current owner.
- grant  output  N  one-hot decode of grant_sel gated by grant_en; all zero when grant_en=0.
- busy  output  1  high in GRANT state.
- timeout  output  1  one-cycle pulse on a forced revoke.

## Operation
- All outputs are registered.
- Reset values: state=IDLE, ptr=0, grant_en=0, grant_sel=0, grant=0, busy=0, timeout=0, hold_cnt=0.
- Internal round-robin pointer `ptr` (SEL_W bits) holds the highest-priority index.
- Winner selection: the first set bit of req scanning ptr, ptr+1, … modulo N (wraps from N-1 to 0).
- IDLE:
  - req==0 → stay in IDLE.
  - Otherwise → GRANT. On that edge, load grant_sel=winner, set grant_en=1, set grant=1<<winner, clear hold_cnt.
- GRANT: hold_cnt increments each cycle and saturates at MAX_HOLD-1. The grant is released on the next edge when any of the following holds:
  - (a) done=1;
  - (b) req[grant_sel]=0;
  - (c) hold_cnt==MAX_HOLD-1 (timeout build only).
- On release: go to GAP, set grant_en=0, set grant=0, set ptr=grant_sel+1 (mod N). grant_sel keeps its value.
- GAP: a one-cycle dead cycle with grant_en=0. It arbitrates exactly as IDLE does: any request → GRANT on the next edge; none → IDLE.
- Simultaneous events:
  - done together with timeout: treated as a normal release; timeout stays 0.
  - A requester raising req during GRANT waits; no preemption.
  - A requester whose req drops before being granted is never granted.
- Single requester held continuously: it is re-granted after each GAP.
- Reset asserted mid-operation: all state and outputs clear asynchronously. The first arbitration after reset starts from ptr=0.

## Timing
- req sampled high in IDLE at edge k → grant_en/grant_sel/grant valid after edge k (1-cycle latency).
- done sampled at edge k → grant_en low after edge k; earliest next grant after edge k+1.
- The gap between consecutive owners is exactly 1 cycle with grant_en=0.
- Timeout build: grant_en stays high for exactly MAX_HOLD cycles if never released. The timeout pulse is high during the first GAP cycle, concurrent with grant_en falling.
- grant and grant_sel change only on the same edges as grant_en; no glitches between states.

## Configuration
- ARB_TIMEOUT_EN defined:
  - hold_cnt and the forced revoke (c) are present.
  - timeout pulses as specified.
- ARB_TIMEOUT_EN undefined:
  - no hold counter;
  - a grant lasts until done or until the owner's req drops;
  - timeout is tied to 0;
  - MAX_HOLD is ignored.

## Test plan
- Reset: assert reset_n=0 mid-simulation with req=4'b1111 → grant_en=0, grant=0, grant_sel=0, busy=0, timeout=0 immediately, without a clock edge.
- Single request, SEL_W=2: req=4'b0100 from IDLE → next cycle grant_en=1, grant_sel=2, grant=4'b0100. Pulse done → next cycle grant_en=0, grant=0. Cycle after that → grant_sel=2 again, since req is still held.
- Round-robin with wrap: req=4'b1111 held, done pulsed on the 2nd cycle of every grant, after reset → owners 0,1,2,3,0,1, each separated by one grant_en=0 cycle.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): req=4'b0001 held, done=0 → grant_en high exactly 16 cycles, then a 1-cycle gap with timeout=1, then regrant of 0. Without the macro: grant_en stays high for 100+ cycles and timeout is never 1.
- Collision: done=1 on the 16th grant cycle (ARB_TIMEOUT_EN, MAX_HOLD=16) → release, timeout stays 0. Separately, req[grant_sel] dropped mid-grant → release on the next edge and ptr advances.
- SEL_W=3: req=8'b1000_0001 with ptr=1 → grant_sel=7, grant=8'b1000_0000 first, then grant_sel=0.

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter owning a shared SEL_W-to-2**SEL_W decoder, with a one-cycle gap between owners.
// Define ARB_TIMEOUT_EN to compile in the MAX_HOLD grant-length limit and the timeout pulse.
module rr_decoder_arbiter #(
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [(2**SEL_W)-1:0]   i_req,
    input  logic                    i_done,
    output logic                    o_grant_en,
    output logic [SEL_W-1:0]        o_grant_sel,
    output logic [(2**SEL_W)-1:0]   o_grant,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int unsigned N = 2**SEL_W;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 2..255");
    end

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_d;
    logic               r_grant_en;
    logic               w_grant_en_d;
    logic [SEL_W-1:0]   r_grant_sel;
    logic [SEL_W-1:0]   w_grant_sel_d;
    logic [N-1:0]       r_grant;
    logic [N-1:0]       w_grant_d;
    logic               r_busy;
    logic               w_busy_d;
    logic               r_timeout;
    logic               w_timeout_d;

    logic               w_any_req;
    logic [SEL_W-1:0]   w_winner;
    logic               w_hold_expired;
    logic               w_release;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0]         r_hold_cnt;
    logic [7:0]         w_hold_cnt_d;

    assign w_hold_expired = (r_hold_cnt == HOLD_LAST);
`else
    assign w_hold_expired = 1'b0;
`endif

    assign w_any_req = |i_req;
    assign w_release = i_done | ~i_req[r_grant_sel] | w_hold_expired;

    // Scan from the farthest offset down so the offset closest to r_ptr wins.
    always_comb begin
        w_winner = r_ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[r_ptr + SEL_W'(i)]) begin
                w_winner = r_ptr + SEL_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_grant_en  <= 1'b0;
            r_grant_sel <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt  <= '0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_grant_en  <= w_grant_en_d;
            r_grant_sel <= w_grant_sel_d;
            r_grant     <= w_grant_d;
            r_busy      <= w_busy_d;
            r_timeout   <= w_timeout_d;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt  <= w_hold_cnt_d;
`endif
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StGap: w_state_d = w_any_req ? StGrant : StIdle;
            StGrant:       w_state_d = w_release ? StGap : StGrant;
            default:       w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_ptr_d       = r_ptr;
        w_grant_en_d  = r_grant_en;
        w_grant_sel_d = r_grant_sel;
        w_grant_d     = r_grant;
        w_busy_d      = r_busy;
        w_timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_cnt_d  = r_hold_cnt;
`endif
        unique case (r_state)
            StIdle, StGap: begin
                w_grant_en_d = 1'b0;
                w_grant_d    = '0;
                w_busy_d     = 1'b0;
                if (w_any_req) begin
                    w_grant_en_d  = 1'b1;
                    w_grant_sel_d = w_winner;
                    w_grant_d     = N'(1) << w_winner;
                    w_busy_d      = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_cnt_d  = '0;
`endif
                end
            end
            StGrant: begin
                if (w_release) begin
                    w_grant_en_d = 1'b0;
                    w_grant_d    = '0;
                    w_busy_d     = 1'b0;
                    w_ptr_d      = r_grant_sel + SEL_W'(1);
                    // Only a revoke forced purely by the hold limit is reported.
                    w_timeout_d  = w_hold_expired & ~i_done & i_req[r_grant_sel];
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_cnt_d = r_hold_cnt + 8'd1;
                end
`endif
            end
            default: begin
                w_grant_en_d = 1'b0;
                w_grant_d    = '0;
                w_busy_d     = 1'b0;
            end
        endcase
    end

    assign o_grant_en  = r_grant_en;
    assign o_grant_sel = r_grant_sel;
    assign o_grant     = r_grant;
    assign o_busy      = r_busy;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Self-checking bench for rr_decoder_arbiter: per-cycle model compare on a 4-requester instance
// plus directed literal checks on it and on an 8-requester instance.
module tb_rr_decoder_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic       g_en;
    logic [1:0] g_sel;
    logic [3:0] g_vec;
    logic       g_busy;
    logic       g_to;

    logic [7:0] req8 = '0;
    logic       done8 = 1'b0;
    logic       g8_en;
    logic [2:0] g8_sel;
    logic [7:0] g8_vec;
    logic       g8_busy;
    logic       g8_to;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.SEL_W(2), .MAX_HOLD(MAX_HOLD)) u_dut4 (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_req       (req),
        .i_done      (done),
        .o_grant_en  (g_en),
        .o_grant_sel (g_sel),
        .o_grant     (g_vec),
        .o_busy      (g_busy),
        .o_timeout   (g_to)
    );

    rr_decoder_arbiter #(.SEL_W(3), .MAX_HOLD(MAX_HOLD)) u_dut8 (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_req       (req8),
        .i_done      (done8),
        .o_grant_en  (g8_en),
        .o_grant_sel (g8_sel),
        .o_grant     (g8_vec),
        .o_busy      (g8_busy),
        .o_timeout   (g8_to)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the decoder, for how many cycles so far, and where the next scan starts.
    bit m_en;
    int m_sel;
    int m_ptr;
    int m_len;
    bit m_to;

    always @(posedge clk or negedge rst_n) begin
        bit expire;
        bit found;
        int w;
        if (!rst_n) begin
            m_en  <= 1'b0;
            m_sel <= 0;
            m_ptr <= 0;
            m_len <= 0;
            m_to  <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (m_en) begin
                expire = TO_EN && (m_len + 1 == MAX_HOLD);
                if (done || !req[m_sel] || expire) begin
                    m_en  <= 1'b0;
                    m_ptr <= (m_sel + 1) % N;
                    m_to  <= expire && !done && req[m_sel];
                end else begin
                    m_len <= m_len + 1;
                end
            end else begin
                found = 1'b0;
                w = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        w = (m_ptr + k) % N;
                    end
                end
                if (found) begin
                    m_en  <= 1'b1;
                    m_sel <= w;
                    m_len <= 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("model_grant_en", 32'(g_en), 32'(m_en));
        check("model_grant_sel", 32'(g_sel), 32'(m_sel));
        check("model_grant", 32'(g_vec), m_en ? (32'd1 << m_sel) : 32'd0);
        check("model_busy", 32'(g_busy), 32'(m_en));
        check("model_timeout", 32'(g_to), 32'(m_to));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) tick();
        check("rst_grant_en", 32'(g_en), 32'd0);
        check("rst_grant", 32'(g_vec), 32'd0);
        check("rst_grant_sel", 32'(g_sel), 32'd0);
        check("rst_busy", 32'(g_busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request, then re-grant after the gap.
        req = 4'b0100;
        tick();
        check("single_en", 32'(g_en), 32'd1);
        check("single_sel", 32'(g_sel), 32'd2);
        check("single_grant", 32'(g_vec), 32'b0100);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("single_gap_en", 32'(g_en), 32'd0);
        check("single_gap_grant", 32'(g_vec), 32'd0);
        tick();
        check("single_regrant_en", 32'(g_en), 32'd1);
        check("single_regrant_sel", 32'(g_sel), 32'd2);
        req = 4'b0000;
        tick();
        tick();

        // Asynchronous reset mid-grant, without a clock edge.
        req = 4'b1111;
        tick();
        check("pre_rst_sel", 32'(g_sel), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_en", 32'(g_en), 32'd0);
        check("async_rst_grant", 32'(g_vec), 32'd0);
        check("async_rst_sel", 32'(g_sel), 32'd0);
        check("async_rst_busy", 32'(g_busy), 32'd0);
        check("async_rst_timeout", 32'(g_to), 32'd0);
        tick();
        rst_n = 1'b1;

        // Round robin with wrap, done on the second grant cycle.
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_en", 32'(g_en), 32'd1);
            check("rr_sel", 32'(g_sel), 32'(k % 4));
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            check("rr_gap_en", 32'(g_en), 32'd0);
        end
        req = 4'b0000;
        tick();

        // Hold limit (or lack of it) with a lone requester.
        req = 4'b0001;
        tick();
        cnt = 0;
        while (g_en && cnt < 110) begin
            cnt++;
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        check("hold_len", 32'(cnt), 32'(MAX_HOLD));
        check("timeout_pulse", 32'(g_to), 32'd1);
        tick();
        check("timeout_regrant_en", 32'(g_en), 32'd1);
        check("timeout_regrant_sel", 32'(g_sel), 32'd0);
        check("timeout_cleared", 32'(g_to), 32'd0);
        repeat (15) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("collision_en", 32'(g_en), 32'd0);
        check("collision_timeout", 32'(g_to), 32'd0);
`else
        check("no_limit_len", 32'(cnt), 32'd110);
        check("no_limit_timeout", 32'(g_to), 32'd0);
`endif
        req = 4'b0000;
        tick();
        tick();

        // Owner drops its request; pointer must move past it.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b0010;
        tick();
        check("drop_sel", 32'(g_sel), 32'd1);
        req = 4'b1001;
        tick();
        check("drop_gap_en", 32'(g_en), 32'd0);
        tick();
        check("drop_next_en", 32'(g_en), 32'd1);
        check("drop_next_sel", 32'(g_sel), 32'd3);
        req = 4'b0000;
        tick();
        tick();

        // Eight requesters: pointer at 1 wraps to 7 before 0.
        req8 = 8'b0000_0001;
        tick();
        check("w8_first_sel", 32'(g8_sel), 32'd0);
        done8 = 1'b1;
        req8 = 8'b1000_0001;
        tick();
        done8 = 1'b0;
        check("w8_gap_en", 32'(g8_en), 32'd0);
        tick();
        check("w8_sel7", 32'(g8_sel), 32'd7);
        check("w8_grant7", 32'(g8_vec), 32'h80);
        done8 = 1'b1;
        tick();
        done8 = 1'b0;
        tick();
        check("w8_sel0", 32'(g8_sel), 32'd0);
        check("w8_grant0", 32'(g8_vec), 32'h01);
        check("w8_timeout", 32'(g8_to), 32'd0);
        req8 = 8'b0000_0000;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
